// File: rtl/multiport_memory_pkg.sv
// Types shared by the multiport memory top level and its read ports.
package multiport_memory_pkg;

`include "memory_defs.vh"

    // Clear sequencer states; encodings come from the shared header.
    typedef enum logic {
        ST_CLEAR = `MEM_STATE_CLEAR,
        ST_READY = `MEM_STATE_READY
    } mem_state_e;

endpackage

// File: rtl/memory_defs.vh
// Shared FSM state encodings for the multiport memory.
`ifndef MEMORY_DEFS_VH
`define MEMORY_DEFS_VH

`define MEM_STATE_CLEAR 1'b0
`define MEM_STATE_READY 1'b1

`endif

// File: rtl/memory_read_port.sv
// One registered read port of the multiport memory: address decode with
// range check (unmatched addresses yield zero) and, when MEMORY_BYPASS_EN
// is defined, a write-first bypass of the same-cycle write.
module memory_read_port #(
    parameter int CELL_COUNT = 4,
    parameter int LINE_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(CELL_COUNT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] read_address,
    input  logic [LINE_WIDTH-1:0] cells [CELL_COUNT],
`ifdef MEMORY_BYPASS_EN
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [LINE_WIDTH-1:0] write_data,
`endif
    output logic [LINE_WIDTH-1:0] read_data,
    output logic                  read_valid
);

    logic [LINE_WIDTH-1:0] fetch;
    logic                  take;
    logic [LINE_WIDTH-1:0] read_data_q, read_data_d;
    logic                  read_valid_q, read_valid_d;

    // Select the addressed cell (zero when out of range) and compute next outputs.
    always_comb begin
        fetch = '0;
        for (int i = 0; i < CELL_COUNT; i++) begin
            if (read_address == ADDR_WIDTH'(i)) begin
                fetch = cells[i];
            end
        end
`ifdef MEMORY_BYPASS_EN
        if (write_enable && (write_address == read_address)) begin
            fetch = write_data;
        end
`endif
        take         = active & read_enable;
        read_valid_d = take;
        read_data_d  = take ? fetch : read_data_q;
    end

    // Output registers; data holds its last value when the port is idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;

endmodule

// File: rtl/multiport_memory.sv
// Multiport memory: one synchronous write port, READ_PORTS registered read
// ports and a self-clearing sequencer that zeroes one cell per cycle after
// reset before raising ready. Define MEMORY_BYPASS_EN for write-first
// read-during-write behaviour; the default is read-first.
module multiport_memory
    import multiport_memory_pkg::*;
#(
    parameter int CELL_COUNT = 4,
    parameter int LINE_WIDTH = 8,
    parameter int READ_PORTS = 2,
    parameter int ADDR_WIDTH = $clog2(CELL_COUNT)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             write_enable,
    input  logic [ADDR_WIDTH-1:0]            write_address,
    input  logic [LINE_WIDTH-1:0]            write_data,
    input  logic [READ_PORTS-1:0]            read_enable,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address,
    output logic [READ_PORTS*LINE_WIDTH-1:0] read_data,
    output logic [READ_PORTS-1:0]            read_valid,
    output logic                             ready
);

    localparam logic [ADDR_WIDTH:0]   CELL_LIMIT = (ADDR_WIDTH + 1)'(CELL_COUNT);
    localparam logic [ADDR_WIDTH-1:0] LAST_CELL  = ADDR_WIDTH'(CELL_COUNT - 1);

    mem_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_ptr_q, clear_ptr_d;
    logic                  ready_q, ready_d;

    logic [LINE_WIDTH-1:0] cells_q [CELL_COUNT];

    logic                  user_we;
    logic                  array_we;
    logic [ADDR_WIDTH-1:0] array_addr;
    logic [LINE_WIDTH-1:0] array_data;

    // Array write source: the clear sequencer owns the port until ready,
    // then host writes are accepted if the address is in range.
    always_comb begin
        user_we = ready_q & write_enable & ({1'b0, write_address} < CELL_LIMIT);
        if (state_q == ST_CLEAR) begin
            array_we   = 1'b1;
            array_addr = clear_ptr_q;
            array_data = '0;
        end else begin
            array_we   = user_we;
            array_addr = write_address;
            array_data = write_data;
        end
    end

    // Storage array; deliberately not reset, the sequencer zeroes it instead.
    always_ff @(posedge clock) begin
        if (array_we) begin
            cells_q[array_addr] <= array_data;
        end
    end

    // Clear sequencer next state: walk every cell, then settle in READY.
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        ready_d     = ready_q;
        case (state_q)
            ST_CLEAR: begin
                clear_ptr_d = clear_ptr_q + ADDR_WIDTH'(1);
                if (clear_ptr_q == LAST_CELL) begin
                    state_d     = ST_READY;
                    ready_d     = 1'b1;
                    clear_ptr_d = '0;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // Clear sequencer registers; reset restarts clearing from cell 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_CLEAR;
            clear_ptr_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            ready_q     <= ready_d;
        end
    end

    assign ready = ready_q;

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        memory_read_port #(
            .CELL_COUNT (CELL_COUNT),
            .LINE_WIDTH (LINE_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_port (
            .clock         (clock),
            .reset         (reset),
            .active        (ready_q),
            .read_enable   (read_enable[p]),
            .read_address  (read_address[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .cells         (cells_q),
`ifdef MEMORY_BYPASS_EN
            .write_enable  (user_we),
            .write_address (write_address),
            .write_data    (write_data),
`endif
            .read_data     (read_data[p*LINE_WIDTH +: LINE_WIDTH]),
            .read_valid    (read_valid[p])
        );
    end

endmodule

// File: tb/tb_multiport_memory.sv
// Self-checking bench for multiport_memory (CELL_COUNT=4, LINE_WIDTH=8,
// READ_PORTS=2) using a reference model and per-port expected-data queues.
module tb_multiport_memory;

`ifdef MEMORY_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        write_enable;
    logic [1:0]  write_address;
    logic [7:0]  write_data;
    logic [1:0]  read_enable;
    logic [3:0]  read_address;
    logic [15:0] read_data;
    logic [1:0]  read_valid;
    logic        ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model [4];
    logic [7:0] exp0_q [$];
    logic [7:0] exp1_q [$];
    logic [1:0] pend_re;
    logic [7:0] last_data [2];

    multiport_memory #(
        .CELL_COUNT (4),
        .LINE_WIDTH (8),
        .READ_PORTS (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .read_enable   (read_enable),
        .read_address  (read_address),
        .read_data     (read_data),
        .read_valid    (read_valid),
        .ready         (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] model_read(input logic [1:0] ra, input logic we,
                                              input logic [1:0] wa, input logic [7:0] wd);
        if (BYPASS && we && (wa == ra)) return wd;
        return model[ra];
    endfunction

    // Apply one cycle of inputs; when track is set, push expected read data and update the model.
    task automatic drive(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                         input logic [1:0] re, input logic [1:0] ra0, input logic [1:0] ra1,
                         input bit track);
        write_enable  = we;
        write_address = wa;
        write_data    = wd;
        read_enable   = re;
        read_address  = {ra1, ra0};
        pend_re       = track ? re : 2'b00;
        if (track) begin
            if (re[0]) exp0_q.push_back(model_read(ra0, we, wa, wd));
            if (re[1]) exp1_q.push_back(model_read(ra1, we, wa, wd));
            if (we) model[wa] = wd;
        end
    endtask

    task automatic zero_model();
        for (int c = 0; c < 4; c++) model[c] = 8'h00;
        exp0_q.delete();
        exp1_q.delete();
        last_data[0] = 8'h00;
        last_data[1] = 8'h00;
        pend_re = 2'b00;
    endtask

    task automatic test_reset();
        logic [7:0] got, want;
        drive(1'b0, 2'd0, 8'h00, 2'b00, 2'd0, 2'd0, 1'b0);
        reset = 1'b1;
        #3 reset = 1'b0;
        #10;
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b want 0", ready); end
        n_tests++; if (read_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", read_valid); end
        n_tests++; if (read_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", read_data); end
        @(posedge clock); #1;
        reset = 1'b1;
        zero_model();
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock); #1;
            n_tests++;
            if (ready !== (k == 4)) begin n_fail++; $display("FAIL reset_ready_edge%0d: got %b want %b", k, ready, (k == 4)); end
        end
        for (int s = 0; s < 3; s++) begin
            if (s < 2) drive(1'b0, 2'd0, 8'h00, 2'b11, 2'(2 * s), 2'(2 * s + 1), 1'b1);
            else       drive(1'b0, 2'd0, 8'h00, 2'b00, 2'd0, 2'd0, 1'b1);
            @(posedge clock); #1;
            for (int p = 0; p < 2; p++) begin
                got = read_data[p*8 +: 8];
                if (pend_re[p]) begin
                    want = (p == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
                    n_tests++; if (read_valid[p] !== 1'b1) begin n_fail++; $display("FAIL reset_readback_valid port%0d step%0d: got %b want 1", p, s, read_valid[p]); end
                    n_tests++; if (got !== want) begin n_fail++; $display("FAIL reset_readback_data port%0d step%0d: got %h want %h", p, s, got, want); end
                end else begin
                    n_tests++; if (read_valid[p] !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid port%0d: got %b want 0", p, read_valid[p]); end
                end
                last_data[p] = got;
            end
        end
    endtask

    task automatic test_read_during_write();
        logic [7:0] got, want;
        drive(1'b1, 2'd2, 8'hA5, 2'b01, 2'd2, 2'd0, 1'b1);
        @(posedge clock); #1;
        got  = read_data[7:0];
        want = exp0_q.pop_front();
        n_tests++; if (read_valid[0] !== 1'b1) begin n_fail++; $display("FAIL rdw_valid: got %b want 1", read_valid[0]); end
        n_tests++; if (got !== want) begin n_fail++; $display("FAIL rdw_data: got %h want %h", got, want); end
        n_tests++; if (got !== (BYPASS ? 8'hA5 : 8'h00)) begin n_fail++; $display("FAIL rdw_mode: got %h want %h", got, (BYPASS ? 8'hA5 : 8'h00)); end
        n_tests++; if (read_valid[1] !== 1'b0) begin n_fail++; $display("FAIL rdw_port1_valid: got %b want 0", read_valid[1]); end
        drive(1'b0, 2'd0, 8'h00, 2'b01, 2'd2, 2'd0, 1'b1);
        @(posedge clock); #1;
        got  = read_data[7:0];
        want = exp0_q.pop_front();
        n_tests++; if (got !== want) begin n_fail++; $display("FAIL rdw_followup: got %h want %h", got, want); end
        n_tests++; if (got !== 8'hA5) begin n_fail++; $display("FAIL rdw_followup_const: got %h want a5", got); end
        last_data[0] = got;
    endtask

    task automatic test_same_cell();
        logic [7:0] got, want;
        drive(1'b1, 2'd3, 8'h3C, 2'b00, 2'd0, 2'd0, 1'b1);
        @(posedge clock); #1;
        n_tests++; if (read_valid !== 2'b00) begin n_fail++; $display("FAIL same_write_valid: got %b want 00", read_valid); end
        drive(1'b0, 2'd0, 8'h00, 2'b11, 2'd3, 2'd3, 1'b1);
        @(posedge clock); #1;
        for (int p = 0; p < 2; p++) begin
            got  = read_data[p*8 +: 8];
            want = (p == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
            n_tests++; if (read_valid[p] !== 1'b1) begin n_fail++; $display("FAIL same_valid port%0d: got %b want 1", p, read_valid[p]); end
            n_tests++; if (got !== want) begin n_fail++; $display("FAIL same_data port%0d: got %h want %h", p, got, want); end
            n_tests++; if (got !== 8'h3C) begin n_fail++; $display("FAIL same_const port%0d: got %h want 3c", p, got); end
            last_data[p] = got;
        end
        drive(1'b0, 2'd0, 8'h00, 2'b00, 2'd0, 2'd0, 1'b1);
        @(posedge clock); #1;
        for (int p = 0; p < 2; p++) begin
            n_tests++; if (read_valid[p] !== 1'b0) begin n_fail++; $display("FAIL same_idle_valid port%0d: got %b want 0", p, read_valid[p]); end
            n_tests++; if (read_data[p*8 +: 8] !== last_data[p]) begin n_fail++; $display("FAIL same_hold port%0d: got %h want %h", p, read_data[p*8 +: 8], last_data[p]); end
        end
    endtask

    task automatic test_traffic();
        logic [7:0] got, want;
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, 2'(i % 4), 8'(i % 256), {(i % 5 != 0), 1'b1}, 2'(i % 4), 2'((i + 1) % 4), 1'b1);
            @(posedge clock); #1;
            for (int p = 0; p < 2; p++) begin
                got = read_data[p*8 +: 8];
                if (pend_re[p]) begin
                    want = (p == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
                    n_tests++; if (read_valid[p] !== 1'b1) begin n_fail++; $display("FAIL traffic_valid port%0d cycle%0d: got %b want 1", p, i, read_valid[p]); end
                    n_tests++; if (got !== want) begin n_fail++; $display("FAIL traffic_data port%0d cycle%0d: got %h want %h", p, i, got, want); end
                end else begin
                    n_tests++; if (read_valid[p] !== 1'b0) begin n_fail++; $display("FAIL traffic_idle_valid port%0d cycle%0d: got %b want 0", p, i, read_valid[p]); end
                    n_tests++; if (got !== last_data[p]) begin n_fail++; $display("FAIL traffic_hold port%0d cycle%0d: got %h want %h", p, i, got, last_data[p]); end
                end
                last_data[p] = got;
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] got, want;
        drive(1'b1, 2'd1, 8'h77, 2'b11, 2'd0, 2'd1, 1'b1);
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b want 0", ready); end
        n_tests++; if (read_valid !== 2'b00) begin n_fail++; $display("FAIL midrst_valid: got %b want 00", read_valid); end
        n_tests++; if (read_data !== 16'h0000) begin n_fail++; $display("FAIL midrst_data: got %h want 0000", read_data); end
        zero_model();
        drive(1'b0, 2'd0, 8'h00, 2'b00, 2'd0, 2'd0, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock); #1;
            n_tests++;
            if (ready !== (k == 4)) begin n_fail++; $display("FAIL midrst_ready_edge%0d: got %b want %b", k, ready, (k == 4)); end
        end
        for (int s = 0; s < 2; s++) begin
            drive(1'b0, 2'd0, 8'h00, 2'b11, 2'(2 * s), 2'(2 * s + 1), 1'b1);
            @(posedge clock); #1;
            for (int p = 0; p < 2; p++) begin
                got  = read_data[p*8 +: 8];
                want = (p == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
                n_tests++; if (read_valid[p] !== 1'b1) begin n_fail++; $display("FAIL midrst_readback_valid port%0d step%0d: got %b want 1", p, s, read_valid[p]); end
                n_tests++; if (got !== want) begin n_fail++; $display("FAIL midrst_readback_data port%0d step%0d: got %h want %h", p, s, got, want); end
                last_data[p] = got;
            end
        end
    endtask

    task automatic test_clear_ignore();
        logic [7:0] got, want;
        @(posedge clock); #1;
        reset = 1'b0;
        zero_model();
        drive(1'b1, 2'd1, 8'hFF, 2'b11, 2'd1, 2'd1, 1'b0);
        #2 reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock); #1;
            n_tests++; if (ready !== (k == 4)) begin n_fail++; $display("FAIL clear_ready_edge%0d: got %b want %b", k, ready, (k == 4)); end
            n_tests++; if (read_valid !== 2'b00) begin n_fail++; $display("FAIL clear_valid_edge%0d: got %b want 00", k, read_valid); end
        end
        drive(1'b0, 2'd0, 8'h00, 2'b11, 2'd1, 2'd0, 1'b1);
        @(posedge clock); #1;
        for (int p = 0; p < 2; p++) begin
            got  = read_data[p*8 +: 8];
            want = (p == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
            n_tests++; if (read_valid[p] !== 1'b1) begin n_fail++; $display("FAIL clear_readback_valid port%0d: got %b want 1", p, read_valid[p]); end
            n_tests++; if (got !== want) begin n_fail++; $display("FAIL clear_readback_data port%0d: got %h want %h", p, got, want); end
        end
        n_tests++; if (read_data[7:0] !== 8'h00) begin n_fail++; $display("FAIL clear_write_dropped: got %h want 00", read_data[7:0]); end
    endtask

    initial begin
        test_reset();
        test_read_during_write();
        test_same_cell();
        test_traffic();
        test_mid_reset();
        test_clear_ignore();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
